// File: rtl/sled_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
//   SEG_BLANK : all segments and dp off (active-low bus value)
//   SEG_OFF   : all seven segments off, dp untouched
//   HEX_SEG   : hex nibble -> active-low segments g..a
//   lz_mask   : per-digit leading-zero blank flags
package sled_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bit i is set when nibbles digits-1..i are all zero; digit 0 is never flagged.
    function automatic logic [7:0] lz_mask(input logic [31:0] nibbles,
                                           input int unsigned digits);
        logic [7:0] mask;
        logic       zero_run;
        mask     = '0;
        zero_run = 1'b1;
        for (int unsigned k = 8; k > 1; k--) begin
            if (k - 1 < digits) begin
                zero_run    = zero_run & (nibbles[4*(k-1) +: 4] == 4'h0);
                mask[k-1]   = zero_run;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/sled_scan_if.sv
// Bundle between the value logic (master) and the display driver (slave).
//   en, load, data, dp, blank_lz : control and value from the master
//   pending                      : captured value not yet on the display
//   seg, dig                     : active-low pin drive
interface sled_scan_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp;
    logic                  blank_lz;
    logic                  pending;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     dig;

    modport master (
        output en, load, data, dp, blank_lz,
        input  pending, seg, dig
    );

    modport slave (
        input  en, load, data, dp, blank_lz,
        output pending, seg, dig
    );
endinterface

// File: rtl/sled_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   nibble : 4-bit value
//   seg    : segments g..a, 0 = lit
module sled_decode
    import sled_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = HEX_SEG[nibble];
    end
endmodule

// File: rtl/sled_scan.sv
// Time-multiplexed common-anode seven-segment driver with dead time,
// leading-zero blanking and frame-synchronous value update.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of sled_scan_if (en/load/data/dp/blank_lz in,
//              pending/seg/dig out); seg and dig are registered.
module sled_scan
    import sled_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEAD     = 500
) (
    input  logic        clk,
    input  logic        rst,
    sled_scan_if.slave  bus
);
    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   act_data;
    logic [DIGITS-1:0]     act_dp;
    logic [4*DIGITS-1:0]   pend_data;
    logic [DIGITS-1:0]     pend_dp;
    logic                  pending;
    logic [7:0]            seg_q;
    logic [DIGITS-1:0]     dig_q;

    logic                  slot_end;
    logic                  frame_end;
    logic [31:0]           act_wide;
    logic [7:0]            dp_wide;
    logic [7:0]            lz_vec;
    logic [3:0]            nibble;
    logic [6:0]            dec_seg;

    assign slot_end  = bus.en && (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Widen to fixed 8-digit views so variable selects never leave range.
    always_comb begin
        act_wide                 = '0;
        act_wide[4*DIGITS-1:0]   = act_data;
        dp_wide                  = '0;
        dp_wide[DIGITS-1:0]      = act_dp;
        lz_vec                   = lz_mask(act_wide, DIGITS);
        nibble                   = act_wide[{idx, 2'b00} +: 4];
    end

    sled_decode u_decode (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    // Scan position: counter frozen while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (bus.en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Load on a boundary bypasses the pending stage so it commits in that
    // same cycle; otherwise the latest capture waits for the next boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pending   <= 1'b0;
            act_data  <= '0;
            act_dp    <= '0;
        end else if (bus.load) begin
            pend_data <= bus.data;
            pend_dp   <= bus.dp;
            if (frame_end) begin
                act_data <= bus.data;
                act_dp   <= bus.dp;
                pending  <= 1'b0;
            end else begin
                pending  <= 1'b1;
            end
        end else if (frame_end && pending) begin
            act_data <= pend_data;
            act_dp   <= pend_dp;
            pending  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            dig_q <= '1;
        end else if (!bus.en || (cnt < CNT_DEAD)) begin
            seg_q <= SEG_BLANK;
            dig_q <= '1;
        end else begin
            dig_q <= ~(DIGITS'(1) << idx);
            seg_q <= {~dp_wide[idx], (bus.blank_lz && lz_vec[idx]) ? SEG_OFF : dec_seg};
        end
    end

    assign bus.pending = pending;
    assign bus.seg     = seg_q;
    assign bus.dig     = dig_q;

endmodule

// File: tb/tb_sled_scan.sv
// Directed self-checking bench for sled_scan (DIGITS=4, SCAN_DIV=8, DEAD=2).
module tb_sled_scan;
    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 8;
    localparam int unsigned DEAD     = 2;

    logic clk = 1'b0;
    logic rst;

    sled_scan_if #(.DIGITS(DIGITS)) bus();

    sled_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .DEAD     (DEAD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side scan position: the state the next rising edge will act on.
    int unsigned bcnt = 0;
    int unsigned bidx = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            bcnt = 0;
            bidx = 0;
        end else if (bus.en) begin
            if (bcnt == SCAN_DIV - 1) begin
                bcnt = 0;
                bidx = (bidx == DIGITS - 1) ? 0 : bidx + 1;
            end else begin
                bcnt = bcnt + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic goto_pos(input int unsigned i, input int unsigned c);
        int n;
        n = 0;
        while (!(bidx == i && bcnt == c) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check_eq("goto_timeout", 32'd1, 32'd0);
    endtask

    // Advance to the first lit cycle of digit i and check the pins.
    task automatic show(input string tag, input int unsigned i, input logic [7:0] exp_seg);
        logic [3:0] exp_dig;
        goto_pos(i, DEAD);
        tick();
        exp_dig = ~(4'b0001 << i);
        check_eq($sformatf("%s_d%0d_dig", tag, i), 32'(bus.dig), 32'(exp_dig));
        check_eq($sformatf("%s_d%0d_seg", tag, i), 32'(bus.seg), 32'(exp_seg));
    endtask

    task automatic load_val(input logic [15:0] d, input logic [3:0] p);
        bus.data = d;
        bus.dp   = p;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.load     = 1'b0;
        bus.data     = '0;
        bus.dp       = '0;
        bus.blank_lz = 1'b0;

        // 1. reset and first frame
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("rst_seg", 32'(bus.seg), 32'hFF);
            check_eq("rst_dig", 32'(bus.dig), 32'hF);
            check_eq("rst_pending", 32'(bus.pending), 32'h0);
        end
        rst    = 1'b0;
        bus.en = 1'b1;
        tick();
        check_eq("dead0_dig", 32'(bus.dig), 32'hF);
        check_eq("dead0_seg", 32'(bus.seg), 32'hFF);
        tick();
        check_eq("dead1_dig", 32'(bus.dig), 32'hF);
        tick();
        check_eq("first_dig", 32'(bus.dig), 32'hE);
        check_eq("first_seg", 32'(bus.seg), 32'hC0);
        show("f0", 1, 8'hC0);
        show("f0", 2, 8'hC0);
        show("f0", 3, 8'hC0);

        // 2. scan order
        load_val(16'h1A3F, 4'b0100);
        check_eq("scan_pending", 32'(bus.pending), 32'h1);
        goto_pos(3, SCAN_DIV - 1);
        tick();
        check_eq("scan_commit", 32'(bus.pending), 32'h0);
        show("scan", 0, 8'h8E);
        show("scan", 1, 8'hB0);
        show("scan", 2, 8'h08);
        show("scan", 3, 8'hF9);

        // 3. tear-free update, last load wins
        show("tear", 1, 8'hB0);
        load_val(16'h1234, 4'b0000);
        check_eq("tear_pend1", 32'(bus.pending), 32'h1);
        show("tear_old", 2, 8'h08);
        load_val(16'h5678, 4'b0000);
        show("tear_old", 3, 8'hF9);
        check_eq("tear_pend2", 32'(bus.pending), 32'h1);
        show("tear_new", 0, 8'h80);
        check_eq("tear_pend3", 32'(bus.pending), 32'h0);
        show("tear_new", 1, 8'hF8);
        show("tear_new", 2, 8'h82);
        show("tear_new", 3, 8'h92);

        // 4. load on the frame boundary
        goto_pos(3, SCAN_DIV - 1);
        check_eq("bnd_pend_pre", 32'(bus.pending), 32'h0);
        load_val(16'h00FF, 4'b0000);
        check_eq("bnd_pend_post", 32'(bus.pending), 32'h0);
        show("bnd", 0, 8'h8E);
        check_eq("bnd_pend_d0", 32'(bus.pending), 32'h0);
        show("bnd", 1, 8'h8E);
        show("bnd", 2, 8'hC0);
        show("bnd", 3, 8'hC0);

        // 5. leading-zero blanking
        bus.blank_lz = 1'b1;
        load_val(16'h0005, 4'b0000);
        show("lz5", 0, 8'h92);
        show("lz5", 1, 8'hFF);
        show("lz5", 2, 8'hFF);
        show("lz5", 3, 8'hFF);
        load_val(16'h0000, 4'b0100);
        show("lz0", 0, 8'hC0);
        show("lz0", 1, 8'hFF);
        show("lz0", 2, 8'h7F);
        show("lz0", 3, 8'hFF);
        bus.blank_lz = 1'b0;
        load_val(16'h0000, 4'b0000);
        show("nolz", 0, 8'hC0);
        show("nolz", 1, 8'hC0);
        show("nolz", 2, 8'hC0);
        show("nolz", 3, 8'hC0);

        // 6. enable drop mid-slot
        goto_pos(1, 4);
        tick();
        check_eq("en_pre_dig", 32'(bus.dig), 32'hD);
        bus.en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_eq("en_off_dig", 32'(bus.dig), 32'hF);
            check_eq("en_off_seg", 32'(bus.seg), 32'hFF);
        end
        bus.en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("en_resume_dig", 32'(bus.dig), 32'hD);
            check_eq("en_resume_seg", 32'(bus.seg), 32'hC0);
        end
        tick();
        check_eq("en_next_slot_dead", 32'(bus.dig), 32'hF);

        // reset with a pending value
        load_val(16'h00FF, 4'b0000);
        check_eq("rst_mid_pend1", 32'(bus.pending), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_pend0", 32'(bus.pending), 32'h0);
        check_eq("rst_mid_seg", 32'(bus.seg), 32'hFF);
        check_eq("rst_mid_dig", 32'(bus.dig), 32'hF);
        show("post_rst", 0, 8'hC0);
        show("post_rst", 1, 8'hC0);
        show("post_rst", 2, 8'hC0);
        show("post_rst", 3, 8'hC0);
        show("post_rst_f2", 0, 8'hC0);
        show("post_rst_f2", 1, 8'hC0);
        check_eq("post_rst_pend", 32'(bus.pending), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
